// File: rtl/l1_clreq_arb_if.sv
// Handshake bundle between the L1 stream pointers, the request arbiter and the L2 channel.
// The arbiter uses the master modport; streams and L2 together form the slave side.
interface l1_clreq_arb_if #(
   parameter int nstreams  = 8,
   parameter int sid_width = $clog2(nstreams)
);
   logic [nstreams-1:0]  i_req_v;
   logic [nstreams-1:0]  i_req_r;
   logic                 o_req_v;
   logic                 o_req_r;
   logic [sid_width-1:0] o_req_sid;
   logic                 i_rsp_v;
   logic                 i_rsp_r;
   logic [sid_width-1:0] i_rsp_sid;
   logic [nstreams-1:0]  o_rsp_v;
   logic [nstreams-1:0]  o_idle;
   logic                 o_err;

   modport master (
      input  i_req_v,
      output i_req_r,
      output o_req_v,
      input  o_req_r,
      output o_req_sid,
      input  i_rsp_v,
      output i_rsp_r,
      input  i_rsp_sid,
      output o_rsp_v,
      output o_idle,
      output o_err
   );

   modport slave (
      output i_req_v,
      input  i_req_r,
      input  o_req_v,
      output o_req_r,
      input  o_req_sid,
      output i_rsp_v,
      input  i_rsp_r,
      output i_rsp_sid,
      input  o_rsp_v,
      input  o_idle,
      input  o_err
   );
endinterface

// File: rtl/l1_clreq_arb.sv
// Round-robin arbiter sharing the L2 cacheline-request channel among L1 streams, with
// per-stream outstanding throttling. Define L1_CLREQ_ARB_OREG_EN for a registered request stage.
module l1_clreq_arb #(
   parameter int nstreams  = 8,
   parameter int sid_width = $clog2(nstreams),
   parameter int max_out   = 4,
   parameter int out_width = $clog2(max_out + 1)
) (
   input  logic              clk,
   input  logic              reset,
   l1_clreq_arb_if.master    bus
);
   localparam logic [out_width-1:0] CNT_MAX = out_width'(max_out);
   localparam logic [nstreams-1:0]  ONE_HOT = {{(nstreams-1){1'b0}}, 1'b1};

   logic [out_width-1:0] cnt_q [nstreams];
   logic [out_width-1:0] cnt_d [nstreams];
   logic [sid_width-1:0] rr_ptr_q, rr_ptr_d;
   logic                 o_err_q, o_err_d;

   logic [nstreams-1:0]  elig;
   logic [nstreams-1:0]  inc;
   logic [nstreams-1:0]  dec;
   logic [nstreams-1:0]  zero;
   logic [sid_width-1:0] win;
   logic                 any_elig;
   logic                 req_open;
   logic                 gnt_act;
   logic                 rsp_in_range;

   for (genvar gi = 0; gi < nstreams; gi++) begin : g_stream
      assign zero[gi]        = (cnt_q[gi] == '0);
      assign elig[gi]        = bus.i_req_v[gi] & (cnt_q[gi] < CNT_MAX);
      assign inc[gi]         = gnt_act & (int'(win) == gi);
      assign dec[gi]         = bus.i_rsp_v & (int'(bus.i_rsp_sid) == gi);
      assign bus.o_rsp_v[gi] = dec[gi];
      assign bus.o_idle[gi]  = zero[gi];
   end

   assign rsp_in_range = (int'(bus.i_rsp_sid) < nstreams);
   assign bus.i_rsp_r  = 1'b1;
   assign bus.o_err    = o_err_q;

   // First eligible stream at or above rr_ptr, wrapping at nstreams.
   always_comb begin
      int idx;
      win      = '0;
      any_elig = 1'b0;
      idx      = 0;
      for (int k = 0; k < nstreams; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= nstreams) idx = idx - nstreams;
         if (!any_elig && elig[idx]) begin
            any_elig = 1'b1;
            win      = sid_width'(idx);
         end
      end
   end

`ifdef L1_CLREQ_ARB_OREG_EN
   logic                 o_req_v_q, o_req_v_d;
   logic [sid_width-1:0] o_req_sid_q, o_req_sid_d;

   // The single entry may be refilled in the same cycle L2 drains it.
   assign req_open = ~o_req_v_q | bus.o_req_r;

   always_comb begin
      o_req_v_d   = o_req_v_q;
      o_req_sid_d = o_req_sid_q;
      if (gnt_act) begin
         o_req_v_d   = 1'b1;
         o_req_sid_d = win;
      end else if (bus.o_req_r) begin
         o_req_v_d   = 1'b0;
         o_req_sid_d = '0;
      end
   end

   assign bus.o_req_v   = o_req_v_q;
   assign bus.o_req_sid = o_req_sid_q;
`else
   assign req_open      = bus.o_req_r;
   assign bus.o_req_v   = any_elig;
   assign bus.o_req_sid = any_elig ? win : '0;
`endif

   assign gnt_act     = any_elig & req_open;
   assign bus.i_req_r = gnt_act ? (ONE_HOT << win) : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_act) rr_ptr_d = (int'(win) == nstreams - 1) ? '0 : win + 1'b1;
   end

   // A grant and a response for the same stream cancel; a decrement at zero is an error.
   always_comb begin
      for (int i = 0; i < nstreams; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc[i] && !dec[i]) cnt_d[i] = cnt_q[i] + 1'b1;
         else if (dec[i] && !inc[i] && !zero[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      end
   end

   assign o_err_d = o_err_q | (bus.i_rsp_v & (~rsp_in_range | (|(dec & zero))));

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         o_err_q  <= 1'b0;
         for (int i = 0; i < nstreams; i++) cnt_q[i] <= '0;
`ifdef L1_CLREQ_ARB_OREG_EN
         o_req_v_q   <= 1'b0;
         o_req_sid_q <= '0;
`endif
      end else begin
         rr_ptr_q <= rr_ptr_d;
         o_err_q  <= o_err_d;
         for (int i = 0; i < nstreams; i++) cnt_q[i] <= cnt_d[i];
`ifdef L1_CLREQ_ARB_OREG_EN
         o_req_v_q   <= o_req_v_d;
         o_req_sid_q <= o_req_sid_d;
`endif
      end
   end
endmodule

// File: tb/tb_l1_clreq_arb.sv
// Randomized and directed bench for l1_clreq_arb, checked cycle by cycle against a
// behavioural model of the arbitration, counting and routing rules.
module tb_l1_clreq_arb;
   localparam int NS   = 8;
   localparam int MAXO = 4;
`ifdef L1_CLREQ_ARB_OREG_EN
   localparam bit OREG = 1'b1;
`else
   localparam bit OREG = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   l1_clreq_arb_if #(.nstreams(NS), .sid_width(3)) bus ();

   l1_clreq_arb #(.nstreams(NS), .sid_width(3), .max_out(MAXO), .out_width(3)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model state
   int       m_cnt [NS];
   int       m_ptr;
   bit       m_err;
   bit       m_hv;
   int       m_hs;
   bit       rec_en;
   int       rec_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NS; s++) m_cnt[s] = 0;
      m_ptr = 0;
      m_err = 0;
      m_hv  = 0;
      m_hs  = 0;
   endtask

   // One clock: check DUT outputs against the model mid-cycle, then advance the model.
   task automatic step();
      int         win;
      bit         any;
      bit         grant;
      logic [7:0] e_ir, e_rsp, e_idle;
      logic       e_ov;
      logic [2:0] e_sid;
      #2;
      win = 0;
      any = 0;
      for (int k = 0; k < NS; k++) begin
         int s;
         s = (m_ptr + k) % NS;
         if (!any && bus.i_req_v[s] && m_cnt[s] < MAXO) begin
            any = 1;
            win = s;
         end
      end
      grant = any && (OREG ? (!m_hv || bus.o_req_r) : bus.o_req_r);
      e_ir  = grant ? 8'(1 << win) : 8'h00;
      e_ov  = OREG ? m_hv : any;
      e_sid = OREG ? 3'(m_hs) : (any ? 3'(win) : 3'd0);
      e_rsp = bus.i_rsp_v ? 8'(1 << bus.i_rsp_sid) : 8'h00;
      for (int s = 0; s < NS; s++) e_idle[s] = (m_cnt[s] == 0);
      chk("i_req_r", bus.i_req_r, e_ir);
      chk("o_req_v", bus.o_req_v, e_ov);
      chk("o_req_sid", bus.o_req_sid, e_sid);
      chk("o_rsp_v", bus.o_rsp_v, e_rsp);
      chk("o_idle", bus.o_idle, e_idle);
      chk("o_err", bus.o_err, m_err);
      if (rec_en && bus.o_req_v && bus.o_req_r) rec_q.push_back(int'(bus.o_req_sid));
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int s = 0; s < NS; s++) begin
            bit inc, dec;
            inc = grant && (s == win);
            dec = bus.i_rsp_v && (s == int'(bus.i_rsp_sid));
            if (dec && m_cnt[s] == 0) m_err = 1;
            if (inc && !dec) m_cnt[s]++;
            else if (dec && !inc && m_cnt[s] > 0) m_cnt[s]--;
         end
         if (grant) begin
            m_ptr = (win + 1) % NS;
            m_hv  = 1;
            m_hs  = win;
         end else if (bus.o_req_r) begin
            m_hv = 0;
            m_hs = 0;
         end
      end
      #1;
   endtask

   task automatic drive(input logic [7:0] rv, input logic ordy, input logic rspv, input logic [2:0] rsid);
      bus.i_req_v   = rv;
      bus.o_req_r   = ordy;
      bus.i_rsp_v   = rspv;
      bus.i_rsp_sid = rsid;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(8'h00, 1'b0, 1'b0, 3'd0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      int exp_fair [12];
      exp_fair = '{0, 3, 5, 0, 3, 5, 0, 3, 5, 0, 3, 5};
      n_checks = 0;
      n_errors = 0;
      rec_en   = 0;
      rst      = 1'b1;
      drive(8'h00, 1'b0, 1'b0, 3'd0);
      @(posedge clk);
      #1;
      model_reset();
      step();
      step();
      rst = 1'b0;

      // Fairness: 0,3,5 continuously requesting, no responses.
      drive(8'h29, 1'b1, 1'b0, 3'd0);
      rec_en = 1;
      for (int i = 0; i < 14; i++) step();
      rec_en = 0;
      chk("fair_count", rec_q.size(), 12);
      for (int i = 0; i < 12; i++)
         chk($sformatf("fair_order%0d", i), (i < rec_q.size()) ? rec_q[i] : 32'hDEAD, exp_fair[i]);
      chk("fair_drop_v", bus.o_req_v, 1'b0);
      chk("fair_idle", bus.o_idle & 8'h29, 8'h00);

      // Throttle: stream 2 alone saturates, one response reopens it.
      do_reset();
      drive(8'h04, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 6; i++) step();
      chk("thr_blocked", bus.i_req_r[2], 1'b0);
      drive(8'h04, 1'b1, 1'b1, 3'd2);
      step();
      drive(8'h04, 1'b1, 1'b0, 3'd0);
      chk("thr_reopen", bus.i_req_r[2], 1'b1);
      step();

      // Simultaneous grant and response on stream 1 at count 2.
      do_reset();
      drive(8'h02, 1'b1, 1'b0, 3'd0);
      step();
      step();
      drive(8'h02, 1'b1, 1'b1, 3'd1);
      #1;
      chk("sim_rsp", bus.o_rsp_v, 8'h02);
      chk("sim_gnt", bus.i_req_r, 8'h02);
      step();
      drive(8'h02, 1'b1, 1'b0, 3'd0);
      step();
      step();
      chk("sim_full", bus.i_req_r, 8'h00);

      // Backpressure with streams 4 and 6, then release.
      do_reset();
      drive(8'h50, 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 5; i++) step();
      drive(8'h50, 1'b1, 1'b0, 3'd0);
      rec_q.delete();
      rec_en = 1;
      for (int i = 0; i < 3; i++) step();
      rec_en = 0;
      chk("bp_first", (rec_q.size() > 0) ? rec_q[0] : 32'hDEAD, 4);
      chk("bp_second", (rec_q.size() > 1) ? rec_q[1] : 32'hDEAD, 6);

      // Random traffic; responses only target streams with outstanding requests.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         int s;
         s = $urandom_range(NS - 1);
         bus.i_req_v   = 8'($urandom);
         bus.o_req_r   = ($urandom_range(3) != 0);
         bus.i_rsp_v   = ($urandom_range(2) != 0) && (m_cnt[s] > 0);
         bus.i_rsp_sid = 3'(s);
         step();
      end

      // Error: response to an idle stream is sticky.
      do_reset();
      drive(8'h00, 1'b1, 1'b1, 3'd7);
      step();
      drive(8'h00, 1'b1, 1'b0, 3'd0);
      chk("err_set", bus.o_err, 1'b1);
      chk("err_cnt7", bus.o_idle[7], 1'b1);
      for (int i = 0; i < 3; i++) step();
      chk("err_sticky", bus.o_err, 1'b1);

      // Reset mid-operation with three outstanding on stream 0 and a held request.
      do_reset();
      drive(8'h01, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 3; i++) step();
      drive(8'h00, 1'b0, 1'b0, 3'd0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_req_v", bus.o_req_v, 1'b0);
      chk("rst_idle", bus.o_idle, 8'hFF);
      chk("rst_err", bus.o_err, 1'b0);
      drive(8'h0A, 1'b1, 1'b0, 3'd0);
      #1;
      chk("rst_first_gnt", bus.i_req_r, 8'h02);
      step();
      drive(8'h00, 1'b1, 1'b1, 3'd0);
      step();
      drive(8'h00, 1'b1, 1'b0, 3'd0);
      chk("rst_late_rsp_err", bus.o_err, 1'b1);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
